// File: rtl/pll_wb_pkg.sv
// Shared types and constants for the PLL dynamic-configuration
// Wishbone master and its upstream command logic.
package pll_wb_pkg;

  localparam int PLL_ADDR_W = 5;
  localparam int PLL_DATA_W = 8;

  localparam logic [7:0] MASK_ALL = 8'hFF;

  localparam logic [4:0] REG_CLKOP_DIV    = 5'h02;
  localparam logic [4:0] REG_CLKOP_CPHASE = 5'h03;
  localparam logic [4:0] REG_CLKOS_CPHASE = 5'h05;
  localparam logic [4:0] REG_CLKOS_DIV    = 5'h07;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_WR_PREP,
    ST_WR_REQ,
    ST_RESP
  } state_e;

endpackage

// File: rtl/pll_wb_timeout.sv
// Saturating strobe-cycle counter; flags the last cycle a strobe
// may stay high without an acknowledge.
module pll_wb_timeout #(
  parameter int  LIMIT = 255,
  localparam int CW    = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // next count: clear, count up, or hold at the limit
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != CW'(LIMIT))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // count register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // this unacked cycle brings the count to LIMIT
  assign expired = en && (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/pll_wb_master.sv
// Wishbone initiator for the PLL dynamic-configuration port:
// read, direct write and masked read-modify-write with ACK timeout.
module pll_wb_master
  import pll_wb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_W         = PLL_ADDR_W,
  parameter int DATA_W         = PLL_DATA_W
) (
  input  logic              PLLCLK,
  input  logic              PLLRST,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic              CMD_WE,
  input  logic [ADDR_W-1:0] CMD_ADDR,
  input  logic [DATA_W-1:0] CMD_WDATA,
  input  logic [DATA_W-1:0] CMD_MASK,
  output logic              RSP_VALID,
  output logic [DATA_W-1:0] RSP_RDATA,
  output logic              RSP_ERR,
  output logic              BUSY,
  output logic              PLLSTB,
  output logic              PLLWE,
  output logic [ADDR_W-1:0] PLLADDR,
  output logic [DATA_W-1:0] PLLDATI,
  input  logic [DATA_W-1:0] PLLDATO,
  input  logic              PLLACK
);

  state_e state_q, state_d;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] mask_q, mask_d;
  logic [DATA_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] dati_q, dati_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rmw_q, rmw_d;
  logic              err_q, err_d;
  logic              stb_q, stb_d;
  logic              we_q, we_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic              tmo_expired;

  pll_wb_timeout #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (PLLCLK),
    .rst    (PLLRST),
    .clr    (!stb_q),
    .en     (stb_q && !PLLACK),
    .expired(tmo_expired)
  );

  // command sequencing, bus strobe and response generation
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    mask_d      = mask_q;
    rd_d        = rd_q;
    dati_d      = dati_q;
    rmw_d       = rmw_q;
    err_d       = err_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (CMD_VALID) begin
          addr_d  = CMD_ADDR;
          wdata_d = CMD_WDATA;
          mask_d  = CMD_MASK;
          rd_d    = '0;
          err_d   = 1'b0;
          rmw_d   = 1'b0;
          if (CMD_WE && (CMD_MASK == '1)) begin
            dati_d  = CMD_WDATA;
            state_d = ST_WR_REQ;
          end else begin
            rmw_d   = CMD_WE && (CMD_MASK != '0);
            state_d = ST_RD_REQ;
          end
        end
      end
      ST_RD_REQ: begin
        if (PLLACK) begin
          rd_d    = PLLDATO;
          state_d = rmw_q ? ST_WR_PREP : ST_RESP;
        end else if (tmo_expired) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_WR_PREP: begin
        dati_d  = (rd_q & ~mask_q) | (wdata_q & mask_q);
        state_d = ST_WR_REQ;
      end
      ST_WR_REQ: begin
        if (PLLACK) begin
          state_d = ST_RESP;
        end else if (tmo_expired) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = err_q;
        rsp_rdata_d = err_q ? '0 : rd_q;
        state_d     = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    stb_d = (state_d == ST_RD_REQ) || (state_d == ST_WR_REQ);
    we_d  = (state_d == ST_WR_REQ);
  end

  // state and registered outputs
  always_ff @(posedge PLLCLK) begin
    if (PLLRST) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      mask_q      <= '0;
      rd_q        <= '0;
      dati_q      <= '0;
      rsp_rdata_q <= '0;
      rmw_q       <= 1'b0;
      err_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mask_q      <= mask_d;
      rd_q        <= rd_d;
      dati_q      <= dati_d;
      rsp_rdata_q <= rsp_rdata_d;
      rmw_q       <= rmw_d;
      err_q       <= err_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign CMD_READY = (state_q == ST_IDLE);
  assign BUSY      = (state_q != ST_IDLE);
  assign RSP_VALID = rsp_valid_q;
  assign RSP_RDATA = rsp_rdata_q;
  assign RSP_ERR   = rsp_err_q;
  assign PLLSTB    = stb_q;
  assign PLLWE     = we_q;
  assign PLLADDR   = addr_q;
  assign PLLDATI   = dati_q;

endmodule

// File: tb/tb_pll_wb_master.sv
// Randomized bench for pll_wb_master against a PLL register-file
// model and a command-level reference of expected responses.
module tb_pll_wb_master;

  localparam int T = 8;

  logic       PLLCLK = 1'b0;
  logic       PLLRST;
  logic       CMD_VALID;
  logic       CMD_READY;
  logic       CMD_WE;
  logic [4:0] CMD_ADDR;
  logic [7:0] CMD_WDATA;
  logic [7:0] CMD_MASK;
  logic       RSP_VALID;
  logic [7:0] RSP_RDATA;
  logic       RSP_ERR;
  logic       BUSY;
  logic       PLLSTB;
  logic       PLLWE;
  logic [4:0] PLLADDR;
  logic [7:0] PLLDATI;
  logic [7:0] PLLDATO;
  logic       PLLACK;

  pll_wb_master #(
    .TIMEOUT_CYCLES(T),
    .ADDR_W(5),
    .DATA_W(8)
  ) dut (
    .PLLCLK(PLLCLK), .PLLRST(PLLRST),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_WE(CMD_WE), .CMD_ADDR(CMD_ADDR),
    .CMD_WDATA(CMD_WDATA), .CMD_MASK(CMD_MASK),
    .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA),
    .RSP_ERR(RSP_ERR), .BUSY(BUSY),
    .PLLSTB(PLLSTB), .PLLWE(PLLWE),
    .PLLADDR(PLLADDR), .PLLDATI(PLLDATI),
    .PLLDATO(PLLDATO), .PLLACK(PLLACK)
  );

  always #5 PLLCLK = ~PLLCLK;

  typedef struct {
    logic       we;
    logic [4:0] addr;
    logic [7:0] dati;
    int         len;
  } stb_rec_t;

  int         n_chk = 0;
  int         n_fail = 0;
  bit         no_ack = 1'b0;
  bit         spurious = 1'b0;
  int         ack_delay = 0;
  int         stb_len = 0;
  bit         ack_last = 1'b0;
  stb_rec_t   cur;
  stb_rec_t   stb_q[$];
  logic [7:0] pll_mem[32];
  logic [7:0] ref_mem[32];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // PLL slave: register file, programmable ACK delay, bus checks
  always @(negedge PLLCLK) begin
    if (ack_last) chk("stb_fall", PLLSTB, 0);
    if (PLLSTB === 1'b1) begin
      if (stb_len == 0) begin
        cur.we   = PLLWE;
        cur.addr = PLLADDR;
        cur.dati = PLLDATI;
      end else begin
        chk("stb_stable", {PLLWE, PLLADDR, PLLDATI},
            {cur.we, cur.addr, cur.dati});
      end
      stb_len++;
      cur.len = stb_len;
      PLLDATO = pll_mem[PLLADDR];
      PLLACK  = !no_ack && (stb_len > ack_delay);
      if (PLLACK && PLLWE) pll_mem[PLLADDR] = PLLDATI;
    end else begin
      if (stb_len > 0) begin
        stb_q.push_back(cur);
        stb_len = 0;
      end
      PLLACK  = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
      PLLDATO = 8'($urandom);
    end
    ack_last = (PLLSTB === 1'b1) && PLLACK;
  end

  // one command end to end; expectations from the command rules
  task automatic do_cmd(input logic we, input logic [4:0] a,
                        input logic [7:0] w, input logic [7:0] m,
                        input int d, input bit na);
    int         kind;
    int         exp_lat;
    int         exp_n;
    int         lat;
    bit         got;
    logic [7:0] old;
    logic [7:0] nv;
    logic [7:0] exp_rd;
    old = ref_mem[a];
    nv  = (old & ~m) | (w & m);
    if (!we || m == 8'h00) kind = 0;
    else if (m == 8'hFF)   kind = 1;
    else                   kind = 2;
    if (na) begin
      exp_lat = T + 2; exp_n = 1; exp_rd = 8'h00;
    end else if (kind == 0) begin
      exp_lat = 3 + d; exp_n = 1; exp_rd = old;
    end else if (kind == 1) begin
      exp_lat = 3 + d; exp_n = 1; exp_rd = 8'h00;
    end else begin
      exp_lat = 5 + 2 * d; exp_n = 2; exp_rd = old;
    end
    @(negedge PLLCLK);
    stb_q.delete();
    ack_delay = d;
    no_ack    = na;
    chk("cmd_ready", CMD_READY, 1);
    CMD_VALID = 1'b1;
    CMD_WE    = we;
    CMD_ADDR  = a;
    CMD_WDATA = w;
    CMD_MASK  = m;
    @(posedge PLLCLK);
    #1;
    CMD_VALID = 1'b0;
    CMD_WE    = 1'($urandom);
    CMD_ADDR  = 5'($urandom);
    CMD_WDATA = 8'($urandom);
    CMD_MASK  = 8'($urandom);
    got = 1'b0;
    lat = 0;
    while (!got && lat < T + 20) begin
      @(negedge PLLCLK);
      lat++;
      if (lat == 1) chk("busy", {BUSY, CMD_READY}, 2'b10);
      if (RSP_VALID) begin
        got = 1'b1;
        chk("rsp_lat", lat, exp_lat);
        chk("rsp_err", RSP_ERR, na);
        chk("rsp_rdata", RSP_RDATA, exp_rd);
      end
    end
    chk("rsp_seen", got, 1);
    @(negedge PLLCLK);
    chk("rsp_pulse", RSP_VALID, 0);
    chk("stb_count", stb_q.size(), exp_n);
    if (stb_q.size() >= 1) begin
      chk("stb0_we", stb_q[0].we, kind == 1);
      chk("stb0_addr", stb_q[0].addr, a);
      chk("stb0_len", stb_q[0].len, na ? T : d + 1);
      if (kind == 1) chk("stb0_dati", stb_q[0].dati, w);
    end
    if (stb_q.size() >= 2) begin
      chk("stb1_we", stb_q[1].we, 1);
      chk("stb1_addr", stb_q[1].addr, a);
      chk("stb1_dati", stb_q[1].dati, nv);
      chk("stb1_len", stb_q[1].len, d + 1);
    end
    if (!na && kind == 1) ref_mem[a] = w;
    if (!na && kind == 2) ref_mem[a] = nv;
    no_ack = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int         acc;
    int         rsp;
    int         acc_c[2];
    int         rsp_c[2];
    logic [7:0] rdat[2];
    logic [7:0] e1;
    logic [7:0] e2;
    bit         seen;
    int         extra;

    for (int i = 0; i < 32; i++) begin
      pll_mem[i] = 8'($urandom);
      ref_mem[i] = pll_mem[i];
    end
    PLLRST    = 1'b1;
    CMD_VALID = 1'b0;
    CMD_WE    = 1'b0;
    CMD_ADDR  = '0;
    CMD_WDATA = '0;
    CMD_MASK  = '0;
    repeat (3) @(negedge PLLCLK);
    chk("rst_ready_busy", {CMD_READY, BUSY}, 2'b10);
    chk("rst_rsp", {RSP_VALID, RSP_ERR, RSP_RDATA}, 0);
    chk("rst_bus", {PLLSTB, PLLWE, PLLADDR, PLLDATI}, 0);
    PLLRST = 1'b0;

    pll_mem[3] = 8'hA5; ref_mem[3] = 8'hA5;
    do_cmd(1'b0, 5'h03, 8'h00, 8'h00, 2, 1'b0);
    do_cmd(1'b1, 5'h07, 8'h3C, 8'hFF, 0, 1'b0);
    pll_mem[7] = 8'hF0; ref_mem[7] = 8'hF0;
    do_cmd(1'b1, 5'h07, 8'h05, 8'h0F, 0, 1'b0);
    chk("rmw_mem", pll_mem[7], 8'hF5);
    do_cmd(1'b0, 5'h09, 8'h00, 8'h00, 0, 1'b1);
    do_cmd(1'b1, 5'h0A, 8'h55, 8'h3C, 1, 1'b1);
    do_cmd(1'b1, 5'h0B, 8'h66, 8'hFF, 0, 1'b1);
    do_cmd(1'b0, 5'h0C, 8'h00, 8'h00, T - 1, 1'b0);
    do_cmd(1'b1, 5'h0D, 8'hAA, 8'h00, 1, 1'b0);

    // reset while a direct write strobe waits for ACK
    @(negedge PLLCLK);
    stb_q.delete();
    no_ack    = 1'b1;
    CMD_VALID = 1'b1;
    CMD_WE    = 1'b1;
    CMD_ADDR  = 5'h07;
    CMD_WDATA = 8'h99;
    CMD_MASK  = 8'hFF;
    @(posedge PLLCLK);
    #1;
    CMD_VALID = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5 && !seen; i++) begin
      @(negedge PLLCLK);
      if (PLLSTB && PLLWE) seen = 1'b1;
    end
    chk("rst_wrreq_seen", seen, 1);
    PLLRST = 1'b1;
    @(negedge PLLCLK);
    chk("rst_stb_drop", PLLSTB, 0);
    chk("rst_no_rsp", RSP_VALID, 0);
    @(negedge PLLCLK);
    PLLRST = 1'b0;
    extra = 0;
    repeat (5) begin
      @(negedge PLLCLK);
      if (RSP_VALID) extra++;
    end
    chk("rst_no_rsp_after", extra, 0);
    chk("rst_ready", {CMD_READY, BUSY}, 2'b10);
    no_ack = 1'b0;
    do_cmd(1'b0, 5'h07, 8'h00, 8'h00, 0, 1'b0);

    // back-to-back reads with CMD_VALID held and spurious ACKs
    spurious = 1'b1;
    @(negedge PLLCLK);
    stb_q.delete();
    ack_delay = 1;
    e1 = ref_mem[5'h11];
    e2 = ref_mem[5'h12];
    CMD_VALID = 1'b1;
    CMD_WE    = 1'b0;
    CMD_ADDR  = 5'h11;
    CMD_MASK  = 8'h00;
    acc = 0;
    rsp = 0;
    for (int c = 0; c < 60 && rsp < 2; c++) begin
      if (RSP_VALID) begin
        rsp_c[rsp] = c;
        rdat[rsp]  = RSP_RDATA;
        rsp++;
      end
      if (CMD_VALID && CMD_READY && acc < 2) begin
        acc_c[acc] = c;
        acc++;
      end
      @(posedge PLLCLK);
      #1;
      if (acc == 1) CMD_ADDR = 5'h12;
      if (acc == 2) CMD_VALID = 1'b0;
      @(negedge PLLCLK);
    end
    CMD_VALID = 1'b0;
    chk("b2b_accepts", acc, 2);
    chk("b2b_rsps", rsp, 2);
    if (acc == 2 && rsp == 2) begin
      chk("b2b_order", acc_c[1] >= rsp_c[0], 1);
      chk("b2b_rd0", rdat[0], e1);
      chk("b2b_rd1", rdat[1], e2);
    end
    repeat (2) @(negedge PLLCLK);
    chk("b2b_strobes", stb_q.size(), 2);
    if (stb_q.size() == 2) begin
      chk("b2b_addr0", stb_q[0].addr, 5'h11);
      chk("b2b_addr1", stb_q[1].addr, 5'h12);
    end

    // randomized command mix
    for (int n = 0; n < 60; n++) begin
      logic       we;
      logic [4:0] a;
      logic [7:0] w;
      logic [7:0] m;
      int         sel;
      we  = 1'($urandom);
      a   = 5'($urandom);
      w   = 8'($urandom);
      sel = $urandom_range(0, 3);
      m   = (sel == 0) ? 8'h00 : (sel == 1) ? 8'hFF : 8'($urandom);
      do_cmd(we, a, w, m, $urandom_range(0, 3),
             $urandom_range(0, 7) == 0);
    end
    spurious = 1'b0;

    for (int i = 0; i < 32; i++) chk("mem_final", pll_mem[i], ref_mem[i]);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
